vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Pixel-timing source for the VGA Pong pipeline. Generates the raster
//  counters hcount/vcount, display_en, hsync and vsync that sprite_renderer
//  and the colour mux consume.
//  Also emits frame_tick, a one-cycle pulse at the start of vertical blanking.
//  The game logic uses frame_tick to update ball/paddle positions tear-free.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
//  CNT_W     10   counter width; H_TOTAL and V_TOTAL must both be <= 2**CNT_W
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  pix_ce      in   1      pixel clock enable; state advances only when 1
//  hcount      out  CNT_W  current pixel column, 0..H_TOTAL-1
//  vcount      out  CNT_W  current line, 0..V_TOTAL-1
//  display_en  out  1      1 when hcount < H_ACTIVE and vcount < V_ACTIVE
//  hsync       out  1      horizontal sync, level set by HS_POL
//  vsync       out  1      vertical sync, level set by VS_POL
//  frame_tick  out  1      1-clk pulse on entry to (hcount=0, vcount=V_ACTIVE)
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Reset (async assert, sync release) sets all outputs immediately:
//      hcount = H_TOTAL-1, vcount = V_TOTAL-1, display_en = 0,
//      hsync = !HS_POL, vsync = !VS_POL, frame_tick = 0.
//  - Every output is a flop. Each flop is loaded from the next-count values,
//    so hcount, vcount, display_en, hsync and vsync always describe the same
//    pixel in the same cycle. Added latency is zero.
//  - On a clk edge with pix_ce=1:
//      hcount = (hcount == H_TOTAL-1) ? 0 : hcount+1.
//      On hcount wrap: vcount = (vcount == V_TOTAL-1) ? 0 : vcount+1.
//  - The first pix_ce after reset release yields (0,0) with display_en=1.
//  - On a clk edge with pix_ce=0: counts, display_en and syncs hold;
//    frame_tick = 0.
//  - hsync = HS_POL while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
//    (656..751); otherwise !HS_POL.
//  - vsync = VS_POL while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC
//    (490..491), for the entire line; otherwise !VS_POL.
//  - frame_tick = 1 for exactly one clk: the cycle where the new counts are
//    (0, V_ACTIVE). It fires once per frame and never repeats while the
//    counts are held.
//  - Reset asserted mid-frame forces the reset values asynchronously. No
//    partial pulse is produced after release.
//  - No arithmetic overflow: counts compare against parameters, never rely
//    on CNT_W wrap.
// TESTING
//  1 Reset, release with pix_ce=1 -> cycle 1: hcount=0, vcount=0,
//    display_en=1, hsync=1, vsync=1, frame_tick=0.
//  2 Step one line -> display_en falls on 639->640; hsync 0 at hcount=656;
//    hsync back to 1 at 752; hcount 799->0 increments vcount.
//  3 Run 2 frames with pix_ce=1 -> frame_tick period is 420000 clks;
//    vsync low for exactly 1600 clks (vcount 490..491); 307200 display_en
//    clks per frame.
//  4 pix_ce toggling 1,0,1,0 -> counts advance every 2nd clk; frame_tick
//    high for 1 clk only; frame period is 840000 clks.
//  5 Assert reset at (hcount=300, vcount=100) -> same delta-step outputs:
//    799/524/0/1/1/0; after release, restart as in test 1.
//  6 Any frame -> at (0,480) frame_tick=1 and display_en=0; at (799,524)
//    display_en=0 and the next pix_ce gives (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the VGA Pong pipeline. Produces the pixel/line
//   counters plus display enable and sync strobes for one pixel per pix_ce, and
//   a one-clock frame_tick when the raster enters vertical blanking (so game
//   state can be updated tear-free).
//
//   Every output is registered and loaded from the *next* count values, so all
//   outputs describe the same pixel in the same cycle with no added latency.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   pix_ce     in   1      pixel clock enable; state advances only when 1
//   hcount     out  CNT_W  current pixel column, 0..H_TOTAL-1
//   vcount     out  CNT_W  current line, 0..V_TOTAL-1
//   display_en out  1      inside the visible window
//   hsync      out  1      horizontal sync, active level HS_POL
//   vsync      out  1      vertical sync, active level VS_POL
//   frame_tick out  1      1-clk pulse when counts become (0, V_ACTIVE)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             display_en,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Terminal counts in counter width (H_TOTAL-1 always fits in CNT_W bits).
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // Window boundaries are held one bit wider than the counters: a boundary
   // may equal 2**CNT_W, and comparisons must never depend on counter wrap.
   localparam logic [CNT_W:0] H_ACT_C  = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] HS_BEG_C = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0] HS_END_C = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0] V_ACT_C  = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0] VS_BEG_C = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0] VS_END_C = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] hcount_q, hcount_d;
   logic [CNT_W-1:0] vcount_q, vcount_d;
   logic             display_en_q, display_en_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             frame_tick_q, frame_tick_d;
   logic [CNT_W:0]   h_next_x, v_next_x;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      hcount_d     = hcount_q;
      vcount_d     = vcount_q;
      frame_tick_d = 1'b0;

      if (pix_ce) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
         end else begin
            hcount_d = hcount_q + CNT_W'(1);
         end
      end

      h_next_x = {1'b0, hcount_d};
      v_next_x = {1'b0, vcount_d};

      // Decoded from the next counts: when pix_ce=0 the counts are held, so
      // these reproduce the current values and effectively hold too.
      display_en_d = (h_next_x < H_ACT_C) && (v_next_x < V_ACT_C);
      hsync_d      = ((h_next_x >= HS_BEG_C) && (h_next_x < HS_END_C)) ? HS_POL : ~HS_POL;
      vsync_d      = ((v_next_x >= VS_BEG_C) && (v_next_x < VS_END_C)) ? VS_POL : ~VS_POL;

      // Only an advancing step can land on (0, V_ACTIVE); a held count at that
      // position must not fire again.
      if (pix_ce && (hcount_d == '0) && (v_next_x == V_ACT_C)) begin
         frame_tick_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order between processes.
   // The reset values park the raster on its last pixel so the first enabled
   // pixel after release is (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount_q     <= H_LAST;
         vcount_q     <= V_LAST;
         display_en_q <= 1'b0;
         hsync_q      <= ~HS_POL;
         vsync_q      <= ~VS_POL;
         frame_tick_q <= 1'b0;
      end else begin
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         display_en_q <= display_en_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign hcount     = hcount_q;
   assign vcount     = vcount_q;
   assign display_en = display_en_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clk/reset/pix_ce: "b" uses the standard 640x480 timing,
//   "s" uses a shrunken raster (25 x 19) so whole frames run quickly. The
//   reference model tracks a single linear pixel position per instance and
//   derives column, line, window and sync levels from it with division and
//   range tests.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
   localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 25
   localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 19
   localparam int S_T  = S_HT * S_VT;                  // 475
   localparam int B_HT = 800;
   localparam int B_VT = 525;
   localparam int B_T  = B_HT * B_VT;

   logic       clk;
   logic       reset;
   logic       pix_ce;
   logic [9:0] b_h, b_v;
   logic       b_de, b_hs, b_vs, b_ft;
   logic [4:0] s_h, s_v;
   logic       s_de, s_hs, s_vs, s_ft;
   logic [31:0] b_obs, s_obs;

   int tests = 0;
   int fails = 0;
   int pos_s, pos_b;
   bit ft_s, ft_b;

   vga_timing_gen u_big (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .hcount(b_h), .vcount(b_v), .display_en(b_de),
      .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft)
   );

   vga_timing_gen #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(5)
   ) u_small (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .hcount(s_h), .vcount(s_v), .display_en(s_de),
      .hsync(s_hs), .vsync(s_vs), .frame_tick(s_ft)
   );

   assign b_obs = {12'(b_h), 12'(b_v), 4'b0, b_de, b_hs, b_vs, b_ft};
   assign s_obs = {12'(s_h), 12'(s_v), 4'b0, s_de, s_hs, s_vs, s_ft};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for linear pixel position p (active-low syncs).
   function automatic logic [31:0] model(int p, bit ft, int ha, int hf, int hs, int hb,
                                         int va, int vf, int vs, int vb);
      int   ht;
      int   h;
      int   v;
      logic de, hsy, vsy;
      ht  = ha + hf + hs + hb;
      h   = p % ht;
      v   = p / ht;
      de  = (h < ha) && (v < va);
      hsy = !((h >= ha + hf) && (h < ha + hf + hs));
      vsy = !((v >= va + vf) && (v < va + vf + vs));
      return {12'(h), 12'(v), 4'b0, de, hsy, vsy, ft};
   endfunction

   function automatic logic [31:0] exp_s();
      return model(pos_s, ft_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
   endfunction

   function automatic logic [31:0] exp_b();
      return model(pos_b, ft_b, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction

   function automatic logic [31:0] lit(int h, int v, logic [3:0] flags);
      return {12'(h), 12'(v), 4'b0, flags};
   endfunction

   // Advance one clock and update the models from the inputs seen at the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (reset) begin
         pos_s = S_T - 1; pos_b = B_T - 1; ft_s = 0; ft_b = 0;
      end else if (pix_ce) begin
         pos_s = (pos_s + 1) % S_T;
         pos_b = (pos_b + 1) % B_T;
         ft_s  = (pos_s == S_VA * S_HT);
         ft_b  = (pos_b == 480 * B_HT);
      end else begin
         ft_s = 0; ft_b = 0;
      end
   endtask

   task automatic advance_to(int target);
      for (int i = 0; i < S_T && pos_s != target; i++) begin
         pix_ce = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pix_ce = 1'b0;
      #1;
      tests++;
      if (b_obs !== lit(799, 524, 4'b0110)) begin
         fails++; $display("FAIL reset_async_big: got %h expected %h", b_obs, lit(799, 524, 4'b0110));
      end
      tick(); tick();
      tests++;
      if (s_obs !== exp_s()) begin
         fails++; $display("FAIL reset_small: got %h expected %h", s_obs, exp_s());
      end
      reset = 1'b0; pix_ce = 1'b1;
      tick();
      tests++;
      if (b_obs !== lit(0, 0, 4'b1110)) begin
         fails++; $display("FAIL first_pixel_big: got %h expected %h", b_obs, lit(0, 0, 4'b1110));
      end
      tests++;
      if (s_obs !== exp_s()) begin
         fails++; $display("FAIL first_pixel_small: got %h expected %h", s_obs, exp_s());
      end
   endtask

   task automatic test_line();
      int de_fall = -1, hs_fall = -1, hs_rise = -1;
      logic prev_de, prev_hs;
      for (int i = 0; i < B_HT; i++) begin
         prev_de = b_de; prev_hs = b_hs;
         pix_ce = 1'b1;
         tick();
         if (prev_de && !b_de && de_fall < 0) de_fall = int'(b_h);
         if (prev_hs && !b_hs && hs_fall < 0) hs_fall = int'(b_h);
         if (!prev_hs && b_hs && hs_rise < 0) hs_rise = int'(b_h);
         tests++;
         if (b_obs !== exp_b()) begin
            fails++; $display("FAIL line_big: got %h expected %h", b_obs, exp_b());
         end
      end
      tests++;
      if (de_fall !== 640) begin fails++; $display("FAIL de_fall_col: got %0d expected 640", de_fall); end
      tests++;
      if (hs_fall !== 656) begin fails++; $display("FAIL hs_fall_col: got %0d expected 656", hs_fall); end
      tests++;
      if (hs_rise !== 752) begin fails++; $display("FAIL hs_rise_col: got %0d expected 752", hs_rise); end
      tests++;
      if (b_obs !== lit(0, 1, 4'b1110)) begin
         fails++; $display("FAIL line_wrap: got %h expected %h", b_obs, lit(0, 1, 4'b1110));
      end
   endtask

   task automatic test_frames();
      int ft_at[$];
      int vs_low = 0, de_cnt = 0;
      advance_to(S_T - 1);
      for (int i = 0; i < 2 * S_T; i++) begin
         pix_ce = 1'b1;
         tick();
         if (s_ft) ft_at.push_back(i);
         if (!s_vs) vs_low++;
         if (s_de) de_cnt++;
         tests++;
         if (s_obs !== exp_s()) begin
            fails++; $display("FAIL frames_small: got %h expected %h", s_obs, exp_s());
         end
      end
      tests++;
      if (ft_at.size() != 2) begin
         fails++; $display("FAIL frames_tick_count: got %0d expected 2", ft_at.size());
      end else begin
         tests++;
         if (ft_at[1] - ft_at[0] != S_T) begin
            fails++; $display("FAIL frames_period: got %0d expected %0d", ft_at[1] - ft_at[0], S_T);
         end
      end
      tests++;
      if (vs_low != 2 * S_VS * S_HT) begin
         fails++; $display("FAIL frames_vsync_low: got %0d expected %0d", vs_low, 2 * S_VS * S_HT);
      end
      tests++;
      if (de_cnt != 2 * S_HA * S_VA) begin
         fails++; $display("FAIL frames_de_count: got %0d expected %0d", de_cnt, 2 * S_HA * S_VA);
      end
   endtask

   task automatic test_ce_toggle();
      int ft_at[$];
      for (int i = 0; i < 4 * S_T; i++) begin
         pix_ce = (i % 2 == 0);
         tick();
         if (s_ft) ft_at.push_back(i);
         tests++;
         if (s_obs !== exp_s()) begin
            fails++; $display("FAIL toggle_small: got %h expected %h", s_obs, exp_s());
         end
      end
      tests++;
      if (ft_at.size() != 2) begin
         fails++; $display("FAIL toggle_tick_count: got %0d expected 2", ft_at.size());
      end else begin
         tests++;
         if (ft_at[1] - ft_at[0] != 2 * S_T) begin
            fails++; $display("FAIL toggle_period: got %0d expected %0d", ft_at[1] - ft_at[0], 2 * S_T);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         pix_ce = 1'($urandom_range(0, 1));
         reset  = ($urandom_range(0, 99) == 0);
         tick();
         tests++;
         if (s_obs !== exp_s()) begin
            fails++; $display("FAIL random_small: got %h expected %h", s_obs, exp_s());
         end
         tests++;
         if (b_obs !== exp_b()) begin
            fails++; $display("FAIL random_big: got %h expected %h", b_obs, exp_b());
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_reset_mid();
      advance_to(5 * S_HT + 7);
      #3;
      reset = 1'b1;
      #1;
      pos_s = S_T - 1; pos_b = B_T - 1; ft_s = 0; ft_b = 0;
      tests++;
      if (s_obs !== lit(S_HT - 1, S_VT - 1, 4'b0110)) begin
         fails++; $display("FAIL midreset_small: got %h expected %h", s_obs, lit(S_HT - 1, S_VT - 1, 4'b0110));
      end
      tests++;
      if (b_obs !== lit(799, 524, 4'b0110)) begin
         fails++; $display("FAIL midreset_big: got %h expected %h", b_obs, lit(799, 524, 4'b0110));
      end
      pix_ce = 1'b1;
      tick();
      tests++;
      if (s_obs !== exp_s()) begin
         fails++; $display("FAIL midreset_hold: got %h expected %h", s_obs, exp_s());
      end
      reset = 1'b0;
      tick();
      tests++;
      if (s_obs !== lit(0, 0, 4'b1110)) begin
         fails++; $display("FAIL midreset_restart: got %h expected %h", s_obs, lit(0, 0, 4'b1110));
      end
      tests++;
      if (b_obs !== lit(0, 0, 4'b1110)) begin
         fails++; $display("FAIL midreset_restart_big: got %h expected %h", b_obs, lit(0, 0, 4'b1110));
      end
   endtask

   task automatic test_corners();
      advance_to(S_VA * S_HT);
      tests++;
      if (s_obs !== lit(0, S_VA, 4'b0111)) begin
         fails++; $display("FAIL corner_vblank_entry: got %h expected %h", s_obs, lit(0, S_VA, 4'b0111));
      end
      for (int i = 0; i < 5; i++) begin
         pix_ce = 1'b0;
         tick();
         tests++;
         if (s_obs !== lit(0, S_VA, 4'b0110)) begin
            fails++; $display("FAIL corner_hold: got %h expected %h", s_obs, lit(0, S_VA, 4'b0110));
         end
      end
      advance_to(S_T - 1);
      tests++;
      if (s_obs !== lit(S_HT - 1, S_VT - 1, 4'b0110)) begin
         fails++; $display("FAIL corner_last: got %h expected %h", s_obs, lit(S_HT - 1, S_VT - 1, 4'b0110));
      end
      pix_ce = 1'b1;
      tick();
      tests++;
      if (s_obs !== lit(0, 0, 4'b1110)) begin
         fails++; $display("FAIL corner_wrap: got %h expected %h", s_obs, lit(0, 0, 4'b1110));
      end
   endtask

   initial begin
      reset = 1'b1;
      pix_ce = 1'b0;
      pos_s = S_T - 1; pos_b = B_T - 1; ft_s = 0; ft_b = 0;
      test_reset();
      test_line();
      test_frames();
      test_ce_toggle();
      test_random();
      test_reset_mid();
      test_corners();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
